// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// Purpose:
//   Raster timing generator for a VGA-style display. A horizontal pixel
//   counter and a vertical line counter step once per enabled pixel tick and
//   wrap at the end of each line and frame. Sync pulses, the visible-area
//   flag, end-of-line/frame flags and a frame-start pulse are decoded from
//   the *next* counter values and registered. Every output therefore changes
//   on the same edge as the position it describes: there is no skew between
//   position and decodes.
//
// Parameters:
//   H_VIEW, H_FRONT, H_SYNC, H_BACK : horizontal timing, in pixels
//   V_VIEW, V_FRONT, V_SYNC, V_BACK : vertical timing, in lines
//   SYNC_ACTIVE_LOW                 : 1 = sync pulses drive low, 0 = high
//
// Ports:
//   clk         in   1  pixel clock, all state on the rising edge
//   reset       in   1  synchronous, active-high, overrides en
//   en          in   1  pixel-tick enable, state advances only when high
//   hpos        out 10  horizontal position, 0..H_TOTAL-1
//   vpos        out 10  vertical position, 0..V_TOTAL-1
//   hsync       out  1  horizontal sync
//   vsync       out  1  vertical sync (asserted for whole lines)
//   visible     out  1  position lies inside the active picture
//   hmax        out  1  hpos == H_TOTAL-1
//   vmax        out  1  vpos == V_TOTAL-1
//   frame_start out  1  one-tick pulse on the frame wrap into (0,0)
//   frame       out  8  frame counter, wraps modulo 256
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int H_VIEW          = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VIEW          = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       hmax,
  output logic       vmax,
  output logic       frame_start,
  output logic [7:0] frame
);

  localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

  // Counter end points and decode boundaries, sized to the position width.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VIEW);
  localparam logic [9:0] V_VIS    = 10'(V_VIEW);
  localparam logic [9:0] HS_START = 10'(H_VIEW + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VIEW + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIEW + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VIEW + V_FRONT + V_SYNC);

  // Maps a logical "pulse active" flag onto the configured pin polarity.
  function automatic logic sync_level(input logic active);
    if (SYNC_ACTIVE_LOW != 0) begin
      return ~active;
    end else begin
      return active;
    end
  endfunction

  // Idle level of both sync outputs, used by reset.
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // State registers.
  logic [9:0] hpos_r;
  logic [9:0] vpos_r;
  logic [7:0] frame_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       visible_r;
  logic       hmax_r;
  logic       vmax_r;
  logic       frame_start_r;

  // Next-state values and decodes of those values.
  logic [9:0] hpos_s;
  logic [9:0] vpos_s;
  logic       frame_wrap_s;
  logic       hsync_act_s;
  logic       vsync_act_s;
  logic       visible_s;
  logic       hmax_s;
  logic       vmax_s;

  // Next position: step right, wrap to the next line, wrap to the next frame.
  // The ">=" compares fold any out-of-range value straight back to 0, so the
  // counters cannot get stuck outside their legal ranges.
  always_comb begin
    hpos_s       = hpos_r;
    vpos_s       = vpos_r;
    frame_wrap_s = 1'b0;
    if (en) begin
      if (hpos_r >= H_LAST) begin
        hpos_s = 10'd0;
        if (vpos_r >= V_LAST) begin
          vpos_s       = 10'd0;
          frame_wrap_s = 1'b1;
        end else begin
          vpos_s = vpos_r + 10'd1;
        end
      end else begin
        hpos_s = hpos_r + 10'd1;
      end
    end else begin
      hpos_s = hpos_r;
      vpos_s = vpos_r;
    end
  end

  // Decodes of the next position; registering these keeps them aligned
  // with the position registers.
  always_comb begin
    hsync_act_s = (hpos_s >= HS_START) && (hpos_s < HS_END);
    vsync_act_s = (vpos_s >= VS_START) && (vpos_s < VS_END);
    visible_s   = (hpos_s < H_VIS) && (vpos_s < V_VIS);
    hmax_s      = (hpos_s == H_LAST);
    vmax_s      = (vpos_s == V_LAST);
  end

  // Position, frame count and registered decodes; reset overrides en.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_r        <= 10'd0;
      vpos_r        <= 10'd0;
      frame_r       <= 8'd0;
      hsync_r       <= SYNC_IDLE;
      vsync_r       <= SYNC_IDLE;
      visible_r     <= 1'b1;
      hmax_r        <= 1'b0;
      vmax_r        <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (en) begin
      hpos_r        <= hpos_s;
      vpos_r        <= vpos_s;
      frame_r       <= frame_wrap_s ? (frame_r + 8'd1) : frame_r;
      hsync_r       <= sync_level(hsync_act_s);
      vsync_r       <= sync_level(vsync_act_s);
      visible_r     <= visible_s;
      hmax_r        <= hmax_s;
      vmax_r        <= vmax_s;
      frame_start_r <= frame_wrap_s;
    end else begin
      // Everything holds except the frame pulse, which must not stretch
      // across idle cycles.
      frame_start_r <= 1'b0;
    end
  end

  assign hpos        = hpos_r;
  assign vpos        = vpos_r;
  assign frame       = frame_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign visible     = visible_r;
  assign hmax        = hmax_r;
  assign vmax        = vmax_r;
  assign frame_start = frame_start_r;

endmodule
